// File: rtl/regfile_nr_pkg.sv
// regfile_pkg: shared definitions for the decode-stage register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   ZERO_ADDR               : address of the optionally hardwired-zero register
//   data_t / addr_t / strb_t: default-width data, address and byte-strobe types
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_ADDR  = 0;

    typedef logic [DATA_W_DEF-1:0]   data_t;
    typedef logic [ADDR_W_DEF-1:0]   addr_t;
    typedef logic [DATA_W_DEF/8-1:0] strb_t;

endpackage

// File: rtl/regfile_nr_reg_nbit.sv
// reg_nbit: one register-file entry with per-byte write enables.
//   clk : rising-edge clock
//   rst : asynchronous active-high clear to 0 (overrides any write)
//   en  : per-byte write enable, bit i covers d[8i+7:8i]
//   d   : write data
//   q   : stored value
module reg_nbit #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W/8-1:0] en,
    input  logic [W-1:0]   d,
    output logic [W-1:0]   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int unsigned b = 0; b < W/8; b++) begin
                if (en[b]) q[8*b +: 8] <= d[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/regfile_nr.sv
// regfile_nr: 2**ADDR_W x DATA_W register file, one byte-strobed synchronous
// write port and NUM_RD asynchronous read ports with optional write bypass.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every entry
//   we    : write enable
//   waddr : write address
//   wstrb : byte write strobes, bit i covers wdata[8i+7:8i]
//   wdata : write data
//   raddr : packed read addresses, port k uses [k*ADDR_W +: ADDR_W]
//   rdata : packed read data, port k uses [k*DATA_W +: DATA_W]
module regfile_nr
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: one reg_nbit per entry; the zero register is a constant.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        if (ZERO_R0 != 0 && e == ZERO_ADDR) begin : g_zero
            assign mem[e] = '0;
        end else begin : g_reg
            logic [NB-1:0] en;

            assign en = (we && waddr == ADDR_W'(e)) ? wstrb : '0;

            reg_nbit #(
                .W (DATA_W)
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (wdata),
                .q   (mem[e])
            );
        end
    end

    // Read ports: stored value, then per-byte bypass merge, then zero-register
    // override last so address 0 reads 0 whatever the bypass does.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if (BYPASS != 0 && !rst && we && ra == waddr) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wstrb[b]) rd[8*b +: 8] = wdata[8*b +: 8];
                end
            end
            if (ZERO_R0 != 0 && ra == ADDR_W'(ZERO_ADDR)) rd = '0;
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_nr.sv
module tb_regfile_nr;

    logic        clk;
    logic        rst;

    // 32-bit, 32-entry, 2-port configurations (bypass on: dut_a, off: dut_b)
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata_a;
    logic [63:0] rdata_b;

    // 64-bit, 8-entry, 4-port configuration
    logic        we_w;
    logic [2:0]  waddr_w;
    logic [7:0]  wstrb_w;
    logic [63:0] wdata_w;
    logic [11:0] raddr_w;
    logic [255:0] rdata_w;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference contents
    logic [31:0] m32 [32];
    logic [63:0] m64 [8];

    regfile_nr #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_R0(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a));

    regfile_nr #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b));

    regfile_nr #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .BYPASS(1), .ZERO_R0(1)) dut_w (
        .clk(clk), .rst(rst), .we(we_w), .waddr(waddr_w), .wstrb(wstrb_w), .wdata(wdata_w),
        .raddr(raddr_w), .rdata(rdata_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value of the 32-bit file at address a.
    function automatic logic [31:0] exp32(input int a, input bit byp);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m32[a];
        if (byp && !rst && we && int'(waddr) == a)
            for (int b = 0; b < 4; b++) if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
        return v;
    endfunction

    function automatic logic [63:0] exp64(input int a);
        logic [63:0] v;
        if (a == 0) return 64'h0;
        v = m64[a];
        if (!rst && we_w && int'(waddr_w) == a)
            for (int b = 0; b < 8; b++) if (wstrb_w[b]) v[8*b +: 8] = wdata_w[8*b +: 8];
        return v;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) m32[i] = '0;
        for (int i = 0; i < 8; i++)  m64[i] = '0;
    endtask

    // One write cycle on the 32-bit files; returns at posedge+1.
    task automatic wr32(input int a, input logic [3:0] s, input logic [31:0] d);
        we = 1'b1; waddr = 5'(a); wstrb = s; wdata = d;
        @(posedge clk);
        if (!rst && a != 0)
            for (int b = 0; b < 4; b++) if (s[b]) m32[a][8*b +: 8] = d[8*b +: 8];
        #1;
        we = 1'b0;
    endtask

    task automatic wr64(input int a, input logic [7:0] s, input logic [63:0] d);
        we_w = 1'b1; waddr_w = 3'(a); wstrb_w = s; wdata_w = d;
        @(posedge clk);
        if (!rst && a != 0)
            for (int b = 0; b < 8; b++) if (s[b]) m64[a][8*b +: 8] = d[8*b +: 8];
        #1;
        we_w = 1'b0;
    endtask

    task automatic set_raddr_w(input int a);
        for (int k = 0; k < 4; k++) raddr_w[3*k +: 3] = 3'(a);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            wr32(int'($urandom_range(31, 1)), 4'hF, $urandom);
            wr64(int'($urandom_range(7, 1)), 8'hFF, {$urandom, $urandom});
        end
        @(negedge clk);
        rst = 1'b1;
        clear_models();
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 32; i++) begin
                raddr = {5'(31 - i), 5'(i)};
                set_raddr_w(i % 8);
                #1;
                n_cmp++;
                if (rdata_a !== 64'h0) begin
                    n_bad++;
                    $display("FAIL reset_a phase=%0d addr=%0d got=%h exp=0", phase, i, rdata_a);
                end
                n_cmp++;
                if (rdata_b !== 64'h0) begin
                    n_bad++;
                    $display("FAIL reset_b phase=%0d addr=%0d got=%h exp=0", phase, i, rdata_b);
                end
                n_cmp++;
                if (rdata_w !== 256'h0) begin
                    n_bad++;
                    $display("FAIL reset_w phase=%0d addr=%0d got=%h exp=0", phase, i % 8, rdata_w);
                end
            end
            @(negedge clk);
            rst = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        logic [31:0] e0, e1;
        for (int i = 1; i < 32; i++) wr32(i, 4'hF, 32'hA5A50000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            e0 = (i == 0)  ? 32'h0 : 32'hA5A50000 + 32'(i);
            e1 = (i == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - i);
            n_cmp++;
            if (rdata_a[31:0] !== e0) begin
                n_bad++;
                $display("FAIL full_p0 addr=%0d got=%h exp=%h", i, rdata_a[31:0], e0);
            end
            n_cmp++;
            if (rdata_a[63:32] !== e1) begin
                n_bad++;
                $display("FAIL full_p1 addr=%0d got=%h exp=%h", 31 - i, rdata_a[63:32], e1);
            end
            n_cmp++;
            if (rdata_b !== {e1, e0}) begin
                n_bad++;
                $display("FAIL full_nobyp addr=%0d got=%h exp=%h", i, rdata_b, {e1, e0});
            end
        end
    endtask

    task automatic test_zero_strobe();
        // write to the zero register, bypass cycle included
        we = 1'b1; waddr = 5'd0; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        raddr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rdata_a !== 64'h0) begin
            n_bad++;
            $display("FAIL zero_bypass got=%h exp=0", rdata_a);
        end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        n_cmp++;
        if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
            n_bad++;
            $display("FAIL zero_stored got_a=%h got_b=%h exp=0", rdata_a, rdata_b);
        end
        // partial byte strobes
        wr32(5, 4'hF, 32'h11223344);
        wr32(5, 4'b0101, 32'hAABBCCDD);
        raddr = {5'd5, 5'd5};
        #1;
        n_cmp++;
        if (rdata_a !== {32'h11BB33DD, 32'h11BB33DD}) begin
            n_bad++;
            $display("FAIL strobe_a got=%h exp=11bb33dd x2", rdata_a);
        end
        n_cmp++;
        if (rdata_b[63:32] !== 32'h11BB33DD) begin
            n_bad++;
            $display("FAIL strobe_b got=%h exp=11bb33dd", rdata_b[63:32]);
        end
        // empty strobe: no bypass effect and no state change
        we = 1'b1; waddr = 5'd5; wstrb = 4'h0; wdata = 32'hFFFFFFFF;
        #1;
        n_cmp++;
        if (rdata_a[31:0] !== 32'h11BB33DD) begin
            n_bad++;
            $display("FAIL empty_strb_bypass got=%h exp=11bb33dd", rdata_a[31:0]);
        end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        n_cmp++;
        if (rdata_a[31:0] !== 32'h11BB33DD) begin
            n_bad++;
            $display("FAIL empty_strb_state got=%h exp=11bb33dd", rdata_a[31:0]);
        end
    endtask

    task automatic test_bypass();
        wr32(7, 4'hF, 32'h0);
        we = 1'b1; waddr = 5'd7; wstrb = 4'hF; wdata = 32'h12345678;
        raddr = {5'd3, 5'd7};
        #1;
        n_cmp++;
        if (rdata_a[31:0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL bypass_on got=%h exp=12345678", rdata_a[31:0]);
        end
        n_cmp++;
        if (rdata_b[31:0] !== 32'h0) begin
            n_bad++;
            $display("FAIL bypass_off got=%h exp=00000000", rdata_b[31:0]);
        end
        n_cmp++;
        if (rdata_a[63:32] !== m32[3]) begin
            n_bad++;
            $display("FAIL bypass_other_port got=%h exp=%h", rdata_a[63:32], m32[3]);
        end
        @(posedge clk);
        m32[7] = 32'h12345678;
        #1;
        we = 1'b0;
        #1;
        n_cmp++;
        if (rdata_a[31:0] !== 32'h12345678 || rdata_b[31:0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL bypass_after got_a=%h got_b=%h exp=12345678", rdata_a[31:0], rdata_b[31:0]);
        end
        // partial-strobe bypass merges with stored bytes; dropped before the edge
        we = 1'b1; waddr = 5'd7; wstrb = 4'b1000; wdata = 32'hAAFFFFFF;
        #1;
        n_cmp++;
        if (rdata_a[31:0] !== 32'hAA345678 || rdata_b[31:0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL bypass_merge got_a=%h exp_a=aa345678 got_b=%h exp_b=12345678",
                     rdata_a[31:0], rdata_b[31:0]);
        end
        we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        wr32(9, 4'hF, 32'h5555AAAA);
        wr64(2, 8'hFF, 64'h1);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
        we_w = 1'b1; waddr_w = 3'd2; wstrb_w = 8'hFF; wdata_w = '1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; we = 1'b0; we_w = 1'b0;
        clear_models();
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            set_raddr_w(i % 8);
            #1;
            n_cmp++;
            if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_mid addr=%0d got_a=%h got_b=%h exp=0", i, rdata_a, rdata_b);
            end
            n_cmp++;
            if (rdata_w !== 256'h0) begin
                n_bad++;
                $display("FAIL reset_mid_w addr=%0d got=%h exp=0", i % 8, rdata_w);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random32();
        int a0, a1;
        logic [31:0] ea0, ea1, eb0, eb1;
        for (int n = 0; n < 300; n++) begin
            we    = ($urandom_range(3, 0) != 0);
            waddr = 5'($urandom);
            wstrb = 4'($urandom);
            wdata = $urandom;
            a0 = ($urandom_range(2, 0) == 0) ? int'(waddr) : int'($urandom_range(31, 0));
            a1 = ($urandom_range(2, 0) == 0) ? int'(waddr) : int'($urandom_range(31, 0));
            raddr = {5'(a1), 5'(a0)};
            #1;
            ea0 = exp32(a0, 1'b1); ea1 = exp32(a1, 1'b1);
            eb0 = exp32(a0, 1'b0); eb1 = exp32(a1, 1'b0);
            n_cmp++;
            if (rdata_a !== {ea1, ea0}) begin
                n_bad++;
                $display("FAIL rand_a it=%0d ra=%0d,%0d got=%h exp=%h", n, a0, a1, rdata_a, {ea1, ea0});
            end
            n_cmp++;
            if (rdata_b !== {eb1, eb0}) begin
                n_bad++;
                $display("FAIL rand_b it=%0d ra=%0d,%0d got=%h exp=%h", n, a0, a1, rdata_b, {eb1, eb0});
            end
            @(posedge clk);
            if (we && waddr != 5'd0)
                for (int b = 0; b < 4; b++) if (wstrb[b]) m32[waddr][8*b +: 8] = wdata[8*b +: 8];
            #1;
        end
        we = 1'b0;
    endtask

    task automatic test_wide();
        logic [63:0] e;
        int ra [4];
        // byte strobes with 8-bit strobe
        wr64(5, 8'hFF, 64'h1122334455667788);
        wr64(5, 8'b01010101, 64'hAABBCCDDEEFF0011);
        set_raddr_w(5);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdata_w[64*k +: 64] !== 64'h11BB33DD55FF7711) begin
                n_bad++;
                $display("FAIL wide_strobe port=%0d got=%h exp=11bb33dd55ff7711", k, rdata_w[64*k +: 64]);
            end
        end
        // zero register with bypass active
        we_w = 1'b1; waddr_w = 3'd0; wstrb_w = 8'hFF; wdata_w = '1;
        set_raddr_w(0);
        #1;
        n_cmp++;
        if (rdata_w !== 256'h0) begin
            n_bad++;
            $display("FAIL wide_zero got=%h exp=0", rdata_w);
        end
        we_w = 1'b0;
        @(posedge clk); #1;
        // bypass on all four ports
        wr64(7, 8'hFF, 64'h0);
        we_w = 1'b1; waddr_w = 3'd7; wstrb_w = 8'hFF; wdata_w = 64'h0123456789ABCDEF;
        set_raddr_w(7);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdata_w[64*k +: 64] !== 64'h0123456789ABCDEF) begin
                n_bad++;
                $display("FAIL wide_bypass port=%0d got=%h exp=0123456789abcdef", k, rdata_w[64*k +: 64]);
            end
        end
        wstrb_w = 8'h0F;
        #1;
        n_cmp++;
        if (rdata_w[191:128] !== 64'h0000000089ABCDEF) begin
            n_bad++;
            $display("FAIL wide_bypass_merge got=%h exp=0000000089abcdef", rdata_w[191:128]);
        end
        we_w = 1'b0;
        @(posedge clk); #1;
        // random traffic on the wide configuration
        for (int n = 0; n < 200; n++) begin
            we_w    = ($urandom_range(3, 0) != 0);
            waddr_w = 3'($urandom);
            wstrb_w = 8'($urandom);
            wdata_w = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                ra[k] = ($urandom_range(2, 0) == 0) ? int'(waddr_w) : int'($urandom_range(7, 0));
                raddr_w[3*k +: 3] = 3'(ra[k]);
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp64(ra[k]);
                n_cmp++;
                if (rdata_w[64*k +: 64] !== e) begin
                    n_bad++;
                    $display("FAIL wide_rand it=%0d port=%0d ra=%0d got=%h exp=%h",
                             n, k, ra[k], rdata_w[64*k +: 64], e);
                end
            end
            @(posedge clk);
            if (we_w && waddr_w != 3'd0)
                for (int b = 0; b < 8; b++) if (wstrb_w[b]) m64[waddr_w][8*b +: 8] = wdata_w[8*b +: 8];
            #1;
        end
        we_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; waddr = '0; wstrb = '0; wdata = '0; raddr = '0;
        we_w = 1'b0; waddr_w = '0; wstrb_w = '0; wdata_w = '0; raddr_w = '0;
        clear_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_full();
        test_zero_strobe();
        test_bypass();
        test_reset_mid();
        test_random32();
        test_wide();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
